// File: rtl/decay_scheduler_if.sv
// Bundle of every signal between the decay scheduler and its neighbours:
// the timestep generator, the shared potential memory port and the decay datapath.
interface decay_scheduler_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              timestep;
   logic [1:0]        model_cfg;
   logic [3:0]        decay_rate_cfg;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              dec_start;
   logic [1:0]        dec_model;
   logic [3:0]        dec_rate;
   logic [DATA_W-1:0] dec_potential;
   logic              dec_valid;
   logic [DATA_W-1:0] dec_result;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_grant;
   logic              busy;
   logic              done;
   logic              overrun;
   logic              cfg_err;

   // scheduler side
   modport master (
      input  timestep, model_cfg, decay_rate_cfg, rd_valid, rd_data,
             dec_valid, dec_result, wr_grant,
      output rd_req, rd_addr, dec_start, dec_model, dec_rate, dec_potential,
             wr_req, wr_addr, wr_data, busy, done, overrun, cfg_err
   );

   // environment side (timestep source, memory, decay unit)
   modport slave (
      output timestep, model_cfg, decay_rate_cfg, rd_valid, rd_data,
             dec_valid, dec_result, wr_grant,
      input  rd_req, rd_addr, dec_start, dec_model, dec_rate, dec_potential,
             wr_req, wr_addr, wr_data, busy, done, overrun, cfg_err
   );
endinterface

// File: rtl/decay_scheduler.sv
// Timestep sequencer for the potential-decay datapath. Each timestep pulse
// sweeps neurons 0..NUM_NEURONS-1: read potential, run decay, write back.
// Every output is a register loaded from the next-state decode.
module decay_scheduler #(
   parameter int NUM_NEURONS = 16,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   decay_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_READ     = 3'd1,
      S_WAIT_RD  = 3'd2,
      S_START    = 3'd3,
      S_WAIT_DEC = 3'd4,
      S_WRITE    = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

   // One-hot rates plus the 0011 code are the only ones the decay unit accepts.
   function automatic logic rate_legal(input logic [3:0] rate);
      case (rate)
         4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011: rate_legal = 1'b1;
         default:                                     rate_legal = 1'b0;
      endcase
   endfunction

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_next_addr;
   logic                w_rate_ok;
   logic [3:0]          w_rate_sane;

   logic                r_rd_req;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_dec_start;
   logic [1:0]          r_dec_model;
   logic [3:0]          r_dec_rate;
   logic [DATA_W-1:0]   r_dec_potential;
   logic                r_wr_req;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic                r_busy;
   logic                r_done;
   logic                r_overrun;
   logic                r_cfg_err;

   // Illegal rate codes fall back to divide-by-1.
   always_comb begin
      w_rate_ok = rate_legal(bus.decay_rate_cfg);
      if (w_rate_ok) begin
         w_rate_sane = bus.decay_rate_cfg;
      end else begin
         w_rate_sane = 4'b0001;
      end
   end

   // Next-state and address-counter decode.
   always_comb begin
      w_next_state = r_state;
      w_next_addr  = r_addr;
      case (r_state)
         S_IDLE: begin
            if (bus.timestep) begin
               w_next_state = S_READ;
               w_next_addr  = {ADDR_W{1'b0}};
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_READ:    w_next_state = S_WAIT_RD;
         S_WAIT_RD: begin
            if (bus.rd_valid) begin
               w_next_state = S_START;
            end else begin
               w_next_state = S_WAIT_RD;
            end
         end
         S_START:   w_next_state = S_WAIT_DEC;
         S_WAIT_DEC: begin
            if (bus.dec_valid) begin
               w_next_state = S_WRITE;
            end else begin
               w_next_state = S_WAIT_DEC;
            end
         end
         S_WRITE: begin
            if (bus.wr_grant) begin
               // The counter only advances below the last address, so it never wraps.
               if (r_addr == LAST_ADDR) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_READ;
                  w_next_addr  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end else begin
               w_next_state = S_WRITE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State, counter and registered outputs; reset abandons any sweep in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state         <= S_IDLE;
         r_addr          <= {ADDR_W{1'b0}};
         r_rd_req        <= 1'b0;
         r_rd_addr       <= {ADDR_W{1'b0}};
         r_dec_start     <= 1'b0;
         r_dec_model     <= 2'b00;
         r_dec_rate      <= 4'b0000;
         r_dec_potential <= {DATA_W{1'b0}};
         r_wr_req        <= 1'b0;
         r_wr_addr       <= {ADDR_W{1'b0}};
         r_wr_data       <= {DATA_W{1'b0}};
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_overrun       <= 1'b0;
         r_cfg_err       <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_addr      <= w_next_addr;
         r_busy      <= (w_next_state != S_IDLE);
         r_rd_req    <= (w_next_state == S_READ);
         r_dec_start <= (w_next_state == S_START);
         r_wr_req    <= (w_next_state == S_WRITE);
         r_done      <= (w_next_state == S_DONE);

         // Configuration is frozen at sweep start; late pulses only flag overrun.
         if (bus.timestep && (r_state == S_IDLE)) begin
            r_dec_model <= bus.model_cfg;
            r_dec_rate  <= w_rate_sane;
            if (!w_rate_ok) begin
               r_cfg_err <= 1'b1;
            end
         end else if (bus.timestep) begin
            r_overrun <= 1'b1;
         end

         if (w_next_state == S_READ) begin
            r_rd_addr <= w_next_addr;
         end
         if ((r_state == S_WAIT_RD) && bus.rd_valid) begin
            r_dec_potential <= bus.rd_data;
         end
         if ((r_state == S_WAIT_DEC) && bus.dec_valid) begin
            r_wr_data <= bus.dec_result;
            r_wr_addr <= r_addr;
         end
      end
   end

   assign bus.rd_req        = r_rd_req;
   assign bus.rd_addr       = r_rd_addr;
   assign bus.dec_start     = r_dec_start;
   assign bus.dec_model     = r_dec_model;
   assign bus.dec_rate      = r_dec_rate;
   assign bus.dec_potential = r_dec_potential;
   assign bus.wr_req        = r_wr_req;
   assign bus.wr_addr       = r_wr_addr;
   assign bus.wr_data       = r_wr_data;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.overrun       = r_overrun;
   assign bus.cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_decay_scheduler.sv
// Directed bench for decay_scheduler with NUM_NEURONS=4 and behavioural
// memory / decay-unit / arbiter responders.
module tb_decay_scheduler;
   localparam int NN = 4;
   localparam int AW = 12;
   localparam int DW = 32;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   decay_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   decay_scheduler #(.NUM_NEURONS(NN), .ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0       = 0;

   // responder controls
   bit rand_dly  = 1'b0;
   int hold_addr = -1;
   int hold_n    = 0;
   int rd_cnt    = -1;
   int dec_cnt   = -1;
   int wr_cnt    = 0;
   logic [DW-1:0] rd_hold, dec_hold, wr_first_data;
   logic [AW-1:0] wr_first_addr;
   bit wr_unstable = 1'b0;

   // logs
   int            rd_a_q[$];
   logic [DW-1:0] pot_q[$];
   logic [1:0]    model_q[$];
   logic [3:0]    rate_q[$];
   int            wr_a_q[$];
   logic [DW-1:0] wr_d_q[$];
   int            wr_len_q[$];
   int            done_q[$];
   int            busy_first = -1;
   int            busy_last  = -1;

   always @(posedge CLK) cyc++;

   // Memory, decay unit and arbiter models plus event logging (negedge)
   always @(negedge CLK) begin
      bus.rd_valid   = 1'b0;
      bus.rd_data    = 32'hDEADBEEF;
      bus.dec_valid  = 1'b0;
      bus.dec_result = 32'hBADC0FFE;
      bus.wr_grant   = 1'b0;
      if (RESET) begin
         rd_cnt  = -1;
         dec_cnt = -1;
         wr_cnt  = 0;
      end else begin
         if (rd_cnt == 0) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = rd_hold;
            rd_cnt = -1;
         end else if (rd_cnt > 0) begin
            rd_cnt--;
         end
         if (bus.rd_req) begin
            rd_cnt  = rand_dly ? int'($urandom_range(0, 7)) : 0;
            rd_hold = 32'h41200000 + 32'(bus.rd_addr);
            rd_a_q.push_back(int'(bus.rd_addr));
         end
         if (dec_cnt == 0) begin
            bus.dec_valid  = 1'b1;
            bus.dec_result = dec_hold;
            dec_cnt = -1;
         end else if (dec_cnt > 0) begin
            dec_cnt--;
         end
         if (bus.dec_start) begin
            dec_cnt  = rand_dly ? int'($urandom_range(0, 7)) : 0;
            dec_hold = bus.dec_potential ^ 32'h80000000;
            pot_q.push_back(bus.dec_potential);
            model_q.push_back(bus.dec_model);
            rate_q.push_back(bus.dec_rate);
         end
         if (bus.wr_req) begin
            if (wr_cnt == 0) begin
               wr_first_addr = bus.wr_addr;
               wr_first_data = bus.wr_data;
            end else if ((bus.wr_addr !== wr_first_addr) || (bus.wr_data !== wr_first_data)) begin
               wr_unstable = 1'b1;
            end
            if ((int'(bus.wr_addr) != hold_addr) || (wr_cnt >= hold_n)) begin
               bus.wr_grant = 1'b1;
               wr_a_q.push_back(int'(bus.wr_addr));
               wr_d_q.push_back(bus.wr_data);
               wr_len_q.push_back(wr_cnt + 1);
               wr_cnt = 0;
            end else begin
               wr_cnt++;
            end
         end else begin
            wr_cnt = 0;
         end
         if (bus.done) done_q.push_back(cyc - t0);
         if (bus.busy) begin
            if (busy_first < 0) busy_first = cyc - t0;
            busy_last = cyc - t0;
         end
      end
   end

   task automatic clear_logs();
      rd_a_q.delete(); pot_q.delete(); model_q.delete(); rate_q.delete();
      wr_a_q.delete(); wr_d_q.delete(); wr_len_q.delete(); done_q.delete();
      busy_first = -1; busy_last = -1; wr_unstable = 1'b0;
   endtask

   task automatic start_sweep(input logic [1:0] m, input logic [3:0] r);
      @(negedge CLK);
      bus.model_cfg      = m;
      bus.decay_rate_cfg = r;
      t0 = cyc;
      bus.timestep = 1'b1;
      @(negedge CLK);
      bus.timestep = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_q.size() == 0 && n < 600) begin
         @(posedge CLK);
         n++;
      end
      checks++;
      if (done_q.size() == 0) begin
         failures++;
         $display("FAIL %s_timeout got=no done required=done within 600 cycles", name);
      end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if ({bus.rd_req, bus.dec_start, bus.wr_req, bus.busy, bus.done, bus.overrun, bus.cfg_err,
           bus.dec_model, bus.dec_rate, bus.rd_addr, bus.wr_addr, bus.wr_data, bus.dec_potential} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b rd_req=%b wr_req=%b overrun=%b cfg_err=%b required=all zero",
                  bus.busy, bus.rd_req, bus.wr_req, bus.overrun, bus.cfg_err);
      end
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_basic();
      clear_logs();
      start_sweep(2'b00, 4'b0001);
      wait_done("basic");
      checks++;
      if (wr_a_q.size() != NN) begin
         failures++;
         $display("FAIL basic_write_count got=%0d required=%0d", wr_a_q.size(), NN);
      end
      for (int i = 0; i < NN; i++) begin
         checks++;
         if (wr_a_q[i] != i || wr_d_q[i] !== ((32'h41200000 + 32'(i)) ^ 32'h80000000)) begin
            failures++;
            $display("FAIL basic_write%0d got addr=%0d data=%h required addr=%0d data=%h", i,
                     wr_a_q[i], wr_d_q[i], i, (32'h41200000 + 32'(i)) ^ 32'h80000000);
         end
         checks++;
         if (rd_a_q[i] != i || pot_q[i] !== 32'h41200000 + 32'(i)) begin
            failures++;
            $display("FAIL basic_read%0d got addr=%0d pot=%h required addr=%0d pot=%h", i,
                     rd_a_q[i], pot_q[i], i, 32'h41200000 + 32'(i));
         end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != 21) begin
         failures++;
         $display("FAIL basic_done_cycle got n=%0d cyc=%0d required n=1 cyc=21", done_q.size(), done_q[0]);
      end
      checks++;
      if (busy_first != 1 || busy_last != 21) begin
         failures++;
         $display("FAIL basic_busy_window got=%0d..%0d required=1..21", busy_first, busy_last);
      end
      checks++;
      if (bus.overrun !== 1'b0 || bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_flags got overrun=%b cfg_err=%b busy=%b required=0 0 0",
                  bus.overrun, bus.cfg_err, bus.busy);
      end
   endtask

   task automatic test_random_delays();
      clear_logs();
      rand_dly = 1'b1; hold_addr = 2; hold_n = 3;
      start_sweep(2'b00, 4'b0001);
      wait_done("delays");
      rand_dly = 1'b0; hold_addr = -1; hold_n = 0;
      checks++;
      if (rd_a_q.size() != NN || pot_q.size() != NN || wr_a_q.size() != NN || done_q.size() != 1) begin
         failures++;
         $display("FAIL delays_counts got rd=%0d start=%0d wr=%0d done=%0d required=%0d %0d %0d 1",
                  rd_a_q.size(), pot_q.size(), wr_a_q.size(), done_q.size(), NN, NN, NN);
      end
      for (int i = 0; i < NN; i++) begin
         checks++;
         if (wr_a_q[i] != i || wr_d_q[i] !== ((32'h41200000 + 32'(i)) ^ 32'h80000000)
             || wr_len_q[i] != ((i == 2) ? 4 : 1)) begin
            failures++;
            $display("FAIL delays_write%0d got addr=%0d data=%h held=%0d required addr=%0d held=%0d", i,
                     wr_a_q[i], wr_d_q[i], wr_len_q[i], i, (i == 2) ? 4 : 1);
         end
      end
      checks++;
      if (wr_unstable) begin
         failures++;
         $display("FAIL delays_wr_stable got=unstable required=stable");
      end
   endtask

   task automatic test_cfg_err();
      clear_logs();
      start_sweep(2'b00, 4'b0101);
      repeat (6) @(negedge CLK);
      bus.decay_rate_cfg = 4'b0010;
      wait_done("cfgerr");
      for (int i = 0; i < NN; i++) begin
         checks++;
         if (rate_q[i] !== 4'b0001) begin
            failures++;
            $display("FAIL cfgerr_rate%0d got=%b required=0001", i, rate_q[i]);
         end
      end
      checks++;
      if (bus.cfg_err !== 1'b1 || rate_q.size() != NN) begin
         failures++;
         $display("FAIL cfgerr_flag got cfg_err=%b starts=%0d required=1 %0d", bus.cfg_err, rate_q.size(), NN);
      end
      clear_logs();
      start_sweep(2'b00, 4'b0010);
      wait_done("cfgerr2");
      checks++;
      if (rate_q.size() != NN || rate_q[0] !== 4'b0010 || rate_q[NN-1] !== 4'b0010 || bus.cfg_err !== 1'b1) begin
         failures++;
         $display("FAIL cfgerr_next_sweep got rate=%b cfg_err=%b required rate=0010 cfg_err=1",
                  rate_q[0], bus.cfg_err);
      end
   endtask

   task automatic test_overrun();
      clear_logs();
      start_sweep(2'b00, 4'b0001);
      repeat (5) @(negedge CLK);
      bus.timestep = 1'b1;
      @(negedge CLK);
      bus.timestep = 1'b0;
      wait_done("overrun");
      checks++;
      if (bus.overrun !== 1'b1 || wr_a_q.size() != NN || done_q.size() != 1 || done_q[0] != 21) begin
         failures++;
         $display("FAIL overrun_sweep got overrun=%b writes=%0d dones=%0d done_cyc=%0d required=1 %0d 1 21",
                  bus.overrun, wr_a_q.size(), done_q.size(), done_q[0], NN);
      end
      clear_logs();
      start_sweep(2'b00, 4'b0001);
      wait_done("overrun_fresh");
      checks++;
      if (wr_a_q.size() != NN || rd_a_q[0] != 0 || done_q[0] != 21 || bus.overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_fresh got writes=%0d first_rd=%0d done_cyc=%0d overrun=%b required=%0d 0 21 1",
                  wr_a_q.size(), rd_a_q[0], done_q[0], bus.overrun, NN);
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      start_sweep(2'b10, 4'b1000);
      repeat (8) @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      checks++;
      if ({bus.rd_req, bus.dec_start, bus.wr_req, bus.busy, bus.done, bus.overrun, bus.cfg_err,
           bus.dec_model, bus.dec_rate, bus.rd_addr, bus.wr_addr, bus.wr_data, bus.dec_potential} !== '0) begin
         failures++;
         $display("FAIL midreset_async got busy=%b overrun=%b cfg_err=%b model=%b rate=%b required=all zero",
                  bus.busy, bus.overrun, bus.cfg_err, bus.dec_model, bus.dec_rate);
      end
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      repeat (12) @(negedge CLK);
      checks++;
      if (wr_a_q.size() != 1 || wr_a_q[0] != 0 || done_q.size() != 0) begin
         failures++;
         $display("FAIL midreset_abandon got writes=%0d dones=%0d required writes=1 dones=0",
                  wr_a_q.size(), done_q.size());
      end
      clear_logs();
      start_sweep(2'b00, 4'b0001);
      wait_done("midreset_restart");
      checks++;
      if (rd_a_q[0] != 0 || wr_a_q.size() != NN || done_q[0] != 21) begin
         failures++;
         $display("FAIL midreset_restart got first_rd=%0d writes=%0d done_cyc=%0d required=0 %0d 21",
                  rd_a_q[0], wr_a_q.size(), done_q[0], NN);
      end
   endtask

   task automatic test_model_rate();
      clear_logs();
      start_sweep(2'b01, 4'b0011);
      wait_done("model");
      for (int i = 0; i < NN; i++) begin
         checks++;
         if (model_q[i] !== 2'b01 || rate_q[i] !== 4'b0011) begin
            failures++;
            $display("FAIL model_rate%0d got model=%b rate=%b required model=01 rate=0011",
                     i, model_q[i], rate_q[i]);
         end
      end
      checks++;
      if (bus.cfg_err !== 1'b0 || model_q.size() != NN) begin
         failures++;
         $display("FAIL model_cfg_err got cfg_err=%b starts=%0d required=0 %0d", bus.cfg_err, model_q.size(), NN);
      end
   endtask

   initial begin
      RESET              = 1'b1;
      bus.timestep       = 1'b0;
      bus.model_cfg      = 2'b00;
      bus.decay_rate_cfg = 4'b0001;
      test_reset();
      test_basic();
      test_random_delays();
      test_cfg_err();
      test_overrun();
      test_reset_mid();
      test_model_rate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decay_scheduler.md
Name: decay_scheduler

Overview:
- Timestep sequencer for the potential-decay datapath.
- On each timestep pulse it walks neuron addresses 0..NUM_NEURONS-1 in order. For each neuron it reads the membrane potential from potential memory, hands it to the decay unit with the latched model/decay-rate configuration, and writes the decayed result back.
- It sits between the timestep generator, the potential memory port (shared with the potential adder through wr_grant) and the decay datapath.

Parameters:
NUM_NEURONS, 16, neurons processed per timestep; 1..2^ADDR_W
ADDR_W, 12, neuron address width
DATA_W, 32, membrane potential width (IEEE-754 single)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous active-high reset
timestep  in  1  one-cycle pulse starting a decay sweep
model_cfg  in  2  00 LIF, 01 Izhikevich, 10 quadratic LIF
decay_rate_cfg  in  4  legal codes: 0001, 0010, 0100, 1000, 0011
rd_req  out  1  potential read request, one-cycle pulse
rd_addr  out  ADDR_W  read address
rd_valid  in  1  read data valid
rd_data  in  DATA_W  read potential
dec_start  out  1  decay unit start, one-cycle pulse
dec_model  out  2  latched model
dec_rate  out  4  latched (sanitised) decay rate
dec_potential  out  DATA_W  potential to decay
dec_valid  in  1  decay result valid
dec_result  in  DATA_W  decayed potential
wr_req  out  1  write request, held until granted
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
wr_grant  in  1  memory arbiter grant
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of sweep
overrun  out  1  sticky: timestep arrived while not IDLE
cfg_err  out  1  sticky: illegal decay_rate_cfg latched

Behaviour:
- Reset (async, RESET=1):
  - State goes to IDLE; address counter = 0.
  - All outputs = 0, including the sticky flags.
  - A reset mid-sweep abandons the sweep: no write is issued and no done pulse follows.
- All outputs are registered. The FSM states are below; each state lasts at least 1 cycle.
- IDLE: timestep=1 -> latch model_cfg and decay_rate_cfg, set addr=0, go to READ.
  - Illegal rate code -> latch 0001 (divide by 1) and set cfg_err.
- READ: assert rd_req with rd_addr=addr for exactly 1 cycle -> WAIT_RD.
- WAIT_RD: wait for rd_valid. rd_valid is sampled only in this state and is ignored elsewhere. On rd_valid, capture rd_data into dec_potential -> START.
- START: assert dec_start for 1 cycle, with dec_model, dec_rate and dec_potential stable -> WAIT_DEC.
- WAIT_DEC: wait for dec_valid, sampled only in this state. On dec_valid, capture dec_result into wr_data and set wr_addr=addr -> WRITE.
- WRITE:
  - wr_req is held high with wr_addr and wr_data stable until wr_grant=1, sampled the same cycle.
  - On grant, wr_req falls next cycle.
  - If addr==NUM_NEURONS-1 -> DONE; otherwise addr+1 -> READ.
- DONE: done=1 for 1 cycle -> IDLE.
- Zero-wait latency (rd_valid and dec_valid one cycle after request, wr_grant immediate):
  - 5 cycles per neuron.
  - done is high in cycle 5*NUM_NEURONS+1, where the cycle that samples timestep is cycle 0.
- The address counter never wraps. The sweep ends at NUM_NEURONS-1; for NUM_NEURONS=2^ADDR_W the counter stops at the all-ones value.
- Configuration is frozen for the whole sweep; changes to model_cfg or decay_rate_cfg mid-sweep have no effect until the next sweep.
- timestep in any non-IDLE state (including DONE) is dropped and sets overrun. The current sweep continues unaffected.
- busy=0 only in IDLE. It is registered with state, so busy rises the cycle after timestep is sampled.
- Sticky flags are cleared only by RESET.

Test Plan:
- NUM_NEURONS=4, zero-wait responders, rd_data=addr-tagged values 0x41200000+addr, dec_result=rd_data ^ 0x80000000 -> writes at addresses 0,1,2,3 in order with the matching data; done high exactly in cycle 21; busy high in cycles 1..21.
- Random rd_valid/dec_valid delays (0-7 cycles) and wr_grant withheld 3 cycles on neuron 2 -> wr_req held 4 cycles with stable wr_addr=2 and wr_data; exactly one rd_req, one dec_start and one write per neuron.
- decay_rate_cfg=0101 at timestep -> dec_rate=0001 for all neurons and cfg_err=1; decay_rate_cfg changed to 0010 mid-sweep -> dec_rate still 0001 until the next sweep.
- Second timestep pulse in cycle 7 of a sweep -> overrun=1; sweep completes with exactly NUM_NEURONS writes and a single done; a fresh timestep after done starts a new sweep.
- RESET asserted in WAIT_DEC of neuron 1 -> all outputs 0 asynchronously; no write for neuron 1 and no done; a timestep after deassertion restarts at addr 0.
- model_cfg=01, decay_rate_cfg=0011 -> dec_model=01 and dec_rate=0011 on every dec_start.
